// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// op-field bit positions and the control FSM state type.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MUH  = 3'b001;
  localparam logic [2:0] OP_MULU = 3'b010;
  localparam logic [2:0] OP_MUHU = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_MOD  = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;
  localparam logic [2:0] OP_MODU = 3'b111;

  localparam int unsigned OP_DIV_BIT = 2;
  localparam int unsigned OP_UNS_BIT = 1;
  localparam int unsigned OP_HI_BIT  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; with i_neg tied to the sign bit it
// yields the magnitude of a signed operand.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit with start/busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t r_state, w_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_hi, r_neg_a, r_neg_b;

  logic               w_signed, w_is_div, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic               w_accept, w_div_zero, w_div_ovf, w_special, w_fast_mul, w_direct;
  logic [WIDTH-1:0]   w_special_res;

  assign w_signed = ~op[OP_UNS_BIT];
  assign w_is_div = op[OP_DIV_BIT];
  assign w_neg_a  = w_signed & src_a[WIDTH-1];
  assign w_neg_b  = w_signed & src_b[WIDTH-1];

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.i_val(src_a), .i_neg(w_neg_a), .o_val(w_mag_a));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.i_val(src_b), .i_neg(w_neg_b), .o_val(w_mag_b));

  assign w_accept   = (r_state == S_IDLE) & start & ~flush;
  assign w_div_zero = (src_b == '0);
  assign w_div_ovf  = w_signed & (src_a == MIN_NEG) & (src_b == '1);
  assign w_special  = w_is_div & (w_div_zero | w_div_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) w_special_res = op[OP_HI_BIT] ? src_a : '1;
    else            w_special_res = op[OP_HI_BIT] ? '0 : MIN_NEG;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_fast_prod;

  // Sign/zero extension to 2*WIDTH makes a plain modular product correct for both signednesses
  assign w_ext_a     = w_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign w_ext_b     = w_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign w_fast_prod = w_ext_a * w_ext_b;
  assign w_fast_mul  = ~w_is_div;
`else
  assign w_fast_mul  = 1'b0;
`endif

  assign w_direct = w_special | w_fast_mul;

  // Multiply step: conditional add of the multiplicand into the high half, then shift right
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift {rem,quot} left, keep the trial difference when it does not borrow
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_fix_res;

  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_prod_fix)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_quo_fix)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_a), .o_val(w_rem_fix)
  );

  always_comb begin
    w_fix_res = '0;
    if (r_is_div) w_fix_res = r_hi ? w_rem_fix : w_quo_fix;
    else          w_fix_res = r_hi ? w_prod_fix[2*WIDTH-1:WIDTH] : w_prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_direct ? S_DONE : S_RUN;
      S_RUN:   if (flush) w_next = S_IDLE;
               else if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  assign result = r_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_is_div <= 1'b0;
      r_hi     <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= w_is_div;
            r_hi     <= op[OP_HI_BIT];
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_cnt    <= CNT_W'(WIDTH);
            if (w_is_div) begin
              r_acc <= {{WIDTH{1'b0}}, w_mag_a};
              r_opb <= w_mag_b;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_mag_b};
              r_opb <= w_mag_a;
            end
            if (w_special) r_result <= w_special_res;
`ifdef MULDIV_FAST_MUL_EN
            else if (w_fast_mul)
              r_result <= op[OP_HI_BIT] ? w_fast_prod[2*WIDTH-1:WIDTH] : w_fast_prod[WIDTH-1:0];
`endif
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!flush) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit for the CPU execute stage.
- Replaces the single-cycle combinational mul/muh/div/mod paths with an iterative radix-2 engine, parameterised in width.
- Uses a start/busy/done handshake so the control unit stalls the pipeline while the engine is busy.
- Defines behaviour for divide-by-zero and signed overflow; the combinational paths left these undefined.

Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  3  operation: bit2 = div(1)/mul(0), bit1 = unsigned, bit0 = high/remainder select
  - MUL=000, MUH=001, MULU=010, MUHU=011, DIV=100, MOD=101, DIVU=110, MODU=111
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- flush  in  1  abort any in-flight operation
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result valid on this cycle
- result  out  WIDTH  selected result; held until the next done

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal accumulator and counter cleared.
  - Reset overrides start and flush.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at edge T: latch op and operand signs.
  - Convert operands to magnitudes; signed ops take the two's-complement abs; unsigned ops pass through.
  - Go to RUN with counter=WIDTH.
- Special cases are decided at acceptance and go directly to DONE (done at T+1):
  - Divide by zero: DIV/DIVU give all-ones; MOD/MODU give src_a.
  - DIV with src_a = MIN_NEG and src_b = −1: result MIN_NEG. MOD: result 0.
- RUN, one iteration per cycle for WIDTH cycles:
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder and quotient held in a 2·WIDTH register.
  - Counter decrements each cycle; go to FIX when counter reaches 1.
- FIX, one cycle of sign correction:
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - Select low/high or quotient/remainder per op[0], and register it into result.
- DONE: done=1 for exactly one cycle, then IDLE.
- Normal latency: accepted at T, done at T+WIDTH+2. busy is high for cycles T+1 through T+WIDTH+2.
- Handshake rules:
  - start while busy=1, including the DONE cycle, is ignored; no queuing.
  - src_a, src_b and op need only be valid on the accepting edge.
- flush:
  - From any non-IDLE state: next state is IDLE, busy falls the next cycle, done is not asserted, result is unchanged.
  - flush and start together in IDLE: flush wins and start is ignored.
- result changes only on a registered write in FIX or on a special-case acceptance. Outside done it holds its last value.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops compute the full product with a combinational signed/unsigned multiplier at acceptance.
  - Result is registered directly; DONE follows, so done is at T+1.
  - Divide path is unchanged.
- Undefined: multiply uses the iterative RUN path with latency WIDTH+2.
- The port list is identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding localparams (OP_MUL … OP_MODU);
  - state enum (S_IDLE, S_RUN, S_FIX, S_DONE);
  - helper bit-position constants for op fields (OP_DIV_BIT=2, OP_UNS_BIT=1, OP_HI_BIT=0).
- One combinational sub-module, muldiv_sign_fix, is natural:
  - takes WIDTH-parameterised conditional negate and abs;
  - is instantiated for operand magnitude conversion and for FIX.

Test Plan (WIDTH=32):
- MUL, src_a=7, src_b=0xFFFFFFFD: result 0xFFFFFFEB, done exactly at T+34, busy high T+1..T+34. Build with MULDIV_FAST_MUL_EN: done at T+1.
- MUHU with src_a = src_b = 0xFFFFFFFF gives 0xFFFFFFFE. MUH with the same operands gives 0x00000000. MULU 0x10000 × 0x10000 gives 0x00000000. MUHU with the same operands gives 0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 gives 0xFFFFFFFD. MOD gives 0xFFFFFFFF. DIVU 7/2 gives 3. MODU 7/2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF with done at T+1. MOD 5/0 gives 5. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000. MOD with the same operands gives 0.
- start pulsed at T+5 with different operands during a busy DIV: ignored, and the original result is produced.
  - flush at T+10: busy=0 at T+11, no done pulse, result retains its prior value.
  - flush+start together in IDLE: no acceptance.
- rst_n=0 for one edge mid-RUN: busy=0, done=0, result=0 next cycle. A new start is accepted on the following edge and completes correctly.
